// File: rtl/multi_input_detect.sv
// -----------------------------------------------------------------------------
// multi_input_detect
//
// Multi-channel button conditioner. Each raw pin is synchronised, optionally
// inverted (active-low pins), debounced and edge-detected. A registered
// encoder turns each cycle's press set into one "which button" event. The
// lowest-numbered pressed channel wins.
//
// Optional feature (macro INPUT_DETECT_REPEAT_EN): per-channel auto-repeat.
// While a button is held, press_o pulses again REPEAT_DELAY cycles after the
// original press. After that it pulses every REPEAT_PERIOD cycles. With the
// macro undefined, no repeat logic exists and the REPEAT_* parameters only
// take part in the parameter range checks.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   signal_i     in   [CHANNELS]  raw asynchronous button pins
//   level_o      out  [CHANNELS]  debounced pressed state (1 = pressed)
//   press_o      out  [CHANNELS]  1-cycle pulse per accepted press / repeat
//   release_o    out  [CHANNELS]  1-cycle pulse per accepted release
//   evt_valid_o  out  1           press_o was non-zero the previous cycle
//   evt_idx_o    out  [IDX_W]     lowest index in that press set (held otherwise)
// -----------------------------------------------------------------------------
module multi_input_detect #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW      = 0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  localparam int IDX_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] signal_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic                evt_valid_o,
  output logic [IDX_W-1:0]    evt_idx_o
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter range checks
  // ---------------------------------------------------------------------------
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("multi_input_detect: CHANNELS must be 1..16");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("multi_input_detect: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("multi_input_detect: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("multi_input_detect: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Raw level of an idle (released) pin. The same mask also converts the
  // synchroniser output to "1 = pressed".
  localparam logic [CHANNELS-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? '1 : '0;

  // ---------------------------------------------------------------------------
  // Synchroniser: stage 0 samples the pin, the last stage feeds the debouncer
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
  logic [CHANNELS-1:0] synced;

  always_comb begin
    sync_d[0] = signal_i;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  assign synced = sync_q[SYNC_STAGES-1] ^ IDLE_RAW;

  // ---------------------------------------------------------------------------
  // Debounce. A channel's accepted level flips only after synced has disagreed
  // with it for DEBOUNCE_CYCLES consecutive edges. Any agreement restarts the
  // count, so the counter never needs to wrap.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]    db_cnt_q [CHANNELS];
  logic [CNT_W-1:0]    db_cnt_d [CHANNELS];
  logic [CHANNELS-1:0] stable_q, stable_d;
  logic [CHANNELS-1:0] press_q, press_d;
  logic [CHANNELS-1:0] release_q, release_d;
  logic [CHANNELS-1:0] rpt_fire;

  always_comb begin
    // NOTE: every always_comb output gets a default first. If a path left one
    // unassigned, synthesis would infer a latch.
    stable_d = stable_q;
    for (int c = 0; c < CHANNELS; c++) begin
      db_cnt_d[c] = db_cnt_q[c];
      if (synced[c] == stable_q[c]) begin
        db_cnt_d[c] = '0;
      end else if (db_cnt_q[c] == DB_LAST) begin
        stable_d[c] = synced[c];
        db_cnt_d[c] = '0;
      end else begin
        db_cnt_d[c] = db_cnt_q[c] + CNT_W'(1);
      end
    end
    // Pulses are registered alongside stable so they line up with level_o.
    press_d   = (stable_d & ~stable_q) | rpt_fire;
    release_d = ~stable_d & stable_q;
  end

`ifdef INPUT_DETECT_REPEAT_EN
  // ---------------------------------------------------------------------------
  // Auto-repeat. The counter runs while the button stays held. Phase 0 waits
  // for REPEAT_DELAY and phase 1 fires every REPEAT_PERIOD. A falling stable
  // suppresses the repeat on the same edge, so a repeat never coincides with
  // release_o.
  // ---------------------------------------------------------------------------
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0]    rpt_cnt_q [CHANNELS];
  logic [RPT_W-1:0]    rpt_cnt_d [CHANNELS];
  logic [CHANNELS-1:0] rpt_phase_q, rpt_phase_d;

  always_comb begin
    rpt_fire    = '0;
    rpt_phase_d = rpt_phase_q;
    for (int c = 0; c < CHANNELS; c++) begin
      rpt_cnt_d[c] = rpt_cnt_q[c];
      if (!stable_q[c] || !stable_d[c]) begin
        // Released, or releasing on this edge.
        rpt_cnt_d[c]   = '0;
        rpt_phase_d[c] = 1'b0;
      end else if (rpt_cnt_q[c] == (rpt_phase_q[c] ? RP_LAST : RD_LAST)) begin
        rpt_fire[c]    = 1'b1;
        rpt_cnt_d[c]   = '0;
        rpt_phase_d[c] = 1'b1;
      end else begin
        rpt_cnt_d[c] = rpt_cnt_q[c] + RPT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_phase_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        rpt_cnt_q[c] <= '0;
      end
    end else begin
      rpt_phase_q <= rpt_phase_d;
      for (int c = 0; c < CHANNELS; c++) begin
        rpt_cnt_q[c] <= rpt_cnt_d[c];
      end
    end
  end
`else
  assign rpt_fire = '0;
`endif

  // ---------------------------------------------------------------------------
  // Event encoder. It reports the lowest-numbered channel of last cycle's
  // press set and keeps the previous index when nothing was pressed.
  // ---------------------------------------------------------------------------
  logic             evt_valid_q, evt_valid_d;
  logic [IDX_W-1:0] evt_idx_q, evt_idx_d;

  always_comb begin
    evt_valid_d = |press_q;
    evt_idx_d   = evt_idx_q;
    // Scan downwards so the lowest set index is the last one written.
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (press_q[c]) begin
        evt_idx_d = IDX_W'(c);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples pre-edge values, whatever order the statements are in.
    if (rst) begin
      // NOTE: the per-channel counter arrays are ordinary flops, not RAM, so
      // they are cleared here. A button held through reset restarts its full
      // latency.
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= IDLE_RAW;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        db_cnt_q[c] <= '0;
      end
      stable_q    <= '0;
      press_q     <= '0;
      release_q   <= '0;
      evt_valid_q <= 1'b0;
      evt_idx_q   <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
      for (int c = 0; c < CHANNELS; c++) begin
        db_cnt_q[c] <= db_cnt_d[c];
      end
      stable_q    <= stable_d;
      press_q     <= press_d;
      release_q   <= release_d;
      evt_valid_q <= evt_valid_d;
      evt_idx_q   <= evt_idx_d;
    end
  end

  assign level_o     = stable_q;
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign evt_valid_o = evt_valid_q;
  assign evt_idx_o   = evt_idx_q;

endmodule

// File: tb/tb_multi_input_detect.sv
// -----------------------------------------------------------------------------
// tb_multi_input_detect
//
// Drives two instances with the same logical button pattern. One instance has
// active-high pins and the other active-low pins (inverted drive), so both
// must produce identical outputs. A cycle-level reference model, built from
// the behavioural rules (pipeline delay, run length of disagreement, time
// held), predicts every output after every edge. Directed steps cover the
// documented scenarios, and a randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_multi_input_detect;

  localparam int CH  = 4;
  localparam int SS  = 2;
  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] sig;
  logic [CH-1:0] sig_al;

  logic [CH-1:0] lvl, prs, rel;
  logic          ev;
  logic [1:0]    idx;
  logic [CH-1:0] al_lvl, al_prs, al_rel;
  logic          al_ev;
  logic [1:0]    al_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign sig_al = ~sig;

  multi_input_detect #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .signal_i(sig),
    .level_o(lvl), .press_o(prs), .release_o(rel),
    .evt_valid_o(ev), .evt_idx_o(idx)
  );

  multi_input_detect #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .ACTIVE_LOW(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_al (
    .clk(clk), .rst(rst), .signal_i(sig_al),
    .level_o(al_lvl), .press_o(al_prs), .release_o(al_rel),
    .evt_valid_o(al_ev), .evt_idx_o(al_idx)
  );

  // ---------------------------------------------------------------------------
  // Reference model (in "pressed" sense, shared by both instances)
  // ---------------------------------------------------------------------------
  logic [CH-1:0] hist[$];      // raw samples still travelling through the synchroniser
  logic [CH-1:0] m_level, m_press, m_release;
  logic          m_evt;
  logic [1:0]    m_idx;
  int            run[CH];      // consecutive edges synced has disagreed with level
  int            held[CH];     // edges since the accepted press, while held

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < SS; i++) hist.push_back('0);
    m_level = '0; m_press = '0; m_release = '0; m_evt = 1'b0; m_idx = '0;
    for (int c = 0; c < CH; c++) begin
      run[c] = 0;
      held[c] = 0;
    end
  endtask

  task automatic model_step(input logic r, input logic [CH-1:0] pressed);
    logic [CH-1:0] s;
    logic [CH-1:0] np, nr;
    logic          old;
    if (r) begin
      model_reset();
      return;
    end
    // Event encoder acts on the press set visible before this edge.
    m_evt = |m_press;
    for (int c = CH - 1; c >= 0; c--) if (m_press[c]) m_idx = 2'(c);
    // Value the debouncer sees at this edge: raw level from SS edges ago.
    s = hist.pop_front();
    hist.push_back(pressed);
    np = '0; nr = '0;
    for (int c = 0; c < CH; c++) begin
      old = m_level[c];
      if (s[c] != old) begin
        run[c]++;
        if (run[c] == DB) begin
          run[c] = 0;
          m_level[c] = s[c];
          if (s[c]) np[c] = 1'b1; else nr[c] = 1'b1;
        end
      end else begin
        run[c] = 0;
      end
`ifdef INPUT_DETECT_REPEAT_EN
      if (old && m_level[c]) begin
        held[c]++;
        if (held[c] == RD || (held[c] > RD && (held[c] - RD) % RP == 0)) np[c] = 1'b1;
      end else begin
        held[c] = 0;
      end
`endif
    end
    m_press = np;
    m_release = nr;
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("level",      16'(lvl),    16'(m_level));
    check("press",      16'(prs),    16'(m_press));
    check("release",    16'(rel),    16'(m_release));
    check("evt_valid",  16'(ev),     16'(m_evt));
    check("evt_idx",    16'(idx),    16'(m_idx));
    check("al_level",   16'(al_lvl), 16'(m_level));
    check("al_press",   16'(al_prs), 16'(m_press));
    check("al_release", 16'(al_rel), 16'(m_release));
    check("al_evt_v",   16'(al_ev),  16'(m_evt));
    check("al_evt_idx", 16'(al_idx), 16'(m_idx));
  endtask

  // One clock edge: the model consumes the inputs the DUT samples, and the
  // outputs are compared 1 time unit later. Inputs change only after that.
  task automatic tick();
    @(posedge clk);
    model_step(rst, sig);
    #1;
    check_all();
  endtask

  int p2_seen;
  int n_press, n_rel;
  int exp_rpt;

  initial begin
    model_reset();
    rst = 1'b1;
    sig = '0;

    // Reset: every output low, active-low pins idle high.
    tick(); tick();
    check("rst_level", 16'(lvl), 16'h0);
    check("rst_press", 16'(prs), 16'h0);
    check("rst_evt",   16'(ev),  16'h0);
    check("rst_al_lvl", 16'(al_lvl), 16'h0);

    // Single press on ch0: level/press change after edge SS+DB = 6.
    rst = 1'b0;
    sig = 4'b0001;
    repeat (5) tick();
    check("lat_early_level", 16'(lvl), 16'h0);
    tick();
    check("lat_level", 16'(lvl), 16'h1);
    check("lat_press", 16'(prs), 16'h1);
    check("lat_al_press", 16'(al_prs), 16'h1);
    tick();
    check("lat_press_width", 16'(prs), 16'h0);
    check("lat_evt_valid", 16'(ev), 16'h1);
    check("lat_evt_idx",   16'(idx), 16'h0);
    tick();
    check("lat_evt_once", 16'(ev), 16'h0);

    // Bounce on ch2: 3 high / 1 low, never long enough to be accepted.
    p2_seen = 0;
    for (int r = 0; r < 4; r++) begin
      sig = 4'b0101;
      repeat (3) begin tick(); p2_seen += int'(prs[2]); end
      sig = 4'b0001;
      tick(); p2_seen += int'(prs[2]);
    end
    repeat (2) begin tick(); p2_seen += int'(prs[2]); end
    check("bounce_no_press", 16'(p2_seen), 16'd0);
    sig = 4'b0101;
    repeat (8) begin tick(); p2_seen += int'(prs[2]); end
    check("bounce_then_hold", 16'(p2_seen), 16'd1);

    // Release everything, then press ch1 and ch3 together.
    sig = 4'b0000;
    repeat (8) tick();
    sig = 4'b1010;
    repeat (6) tick();
    check("simul_press", 16'(prs), 16'hA);
    tick();
    check("simul_evt_valid", 16'(ev),  16'h1);
    check("simul_evt_idx",   16'(idx), 16'h1);
    check("simul_press_gone", 16'(prs), 16'h0);
    tick();
    check("simul_evt_single", 16'(ev), 16'h0);
    check("simul_idx_hold",   16'(idx), 16'h1);

    // Release: one release pulse per channel, after the same latency.
    sig = 4'b0000;
    n_rel = 0;
    repeat (8) begin tick(); n_rel += $countones(rel); end
    check("release_count", 16'(n_rel), 16'd2);

    // Reset while ch0 is held and accepted.
    sig = 4'b0001;
    repeat (7) tick();
    check("pre_rst_level", 16'(lvl), 16'h1);
    rst = 1'b1;
    tick();
    check("midrst_level", 16'(lvl), 16'h0);
    check("midrst_al_level", 16'(al_lvl), 16'h0);
    check("midrst_evt_idx", 16'(idx), 16'h0);
    rst = 1'b0;
    repeat (5) tick();
    check("rearm_early", 16'(prs), 16'h0);
    tick();
    check("rearm_press", 16'(prs), 16'h1);

    // Keep holding: auto-repeat at +10, +13, +16 (repeat build only).
    n_press = 0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      n_press += int'(prs[0]);
    end
`ifdef INPUT_DETECT_REPEAT_EN
    exp_rpt = 3;
`else
    exp_rpt = 0;
`endif
    check("repeat_count", 16'(n_press), 16'(exp_rpt));
    sig = 4'b0000;
    n_press = 0; n_rel = 0;
    repeat (10) begin tick(); n_press += int'(prs[0]); n_rel += int'(rel[0]); end
    check("repeat_release_once", 16'(n_rel), 16'd1);

    // Randomized phase: random pattern held for 1..10 cycles, rare resets.
    for (int seg = 0; seg < 600; seg++) begin
      sig = 4'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      for (int h = $urandom_range(1, 10); h > 0; h--) begin
        tick();
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_input_detect.md
# multi_input_detect

Parametrised multi-channel input conditioner for the player buttons. Each channel is synchronised, debounced and edge-detected. The block emits per-channel debounced levels, press/release pulses and a single prioritised "which button" event for the game logic. It replaces the single-channel sync + edge chain and sits between the board button pins and the mole/score FSMs.

## Interface
- CHANNELS, 4: number of independent inputs (1–16)
- SYNC_STAGES, 2: synchroniser flops per channel (≥2)
- DEBOUNCE_CYCLES, 500000: consecutive cycles a new level must persist before acceptance (≥1)
- ACTIVE_LOW, 0: 1 = raw pins are low when pressed; inversion is applied after the synchroniser
- REPEAT_DELAY, 25000000: cycles from press to first auto-repeat (repeat build only, ≥1)
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeats (repeat build only, ≥1)

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  reset, synchronous, active-high; sampled on clk rising edge
- signal_i  in  CHANNELS  raw asynchronous button pins
- level_o  out  CHANNELS  debounced pressed state (1 = pressed)
- press_o  out  CHANNELS  one-cycle pulse per accepted press (and per auto-repeat)
- release_o  out  CHANNELS  one-cycle pulse per accepted release
- evt_valid_o  out  1  one-cycle pulse: at least one press_o bit was high the previous cycle
- evt_idx_o  out  clog2(CHANNELS), min 1  index of lowest-numbered channel in that press set

## Operation
- Synchroniser: SYNC_STAGES flops per channel. On reset, every stage loads the raw inactive level (ACTIVE_LOW ? 1 : 0). Output is XORed with ACTIVE_LOW to give synced (1 = pressed).
- Debounce, per channel: counter of width clog2(DEBOUNCE_CYCLES+1) and register stable.
  - synced == stable: counter ← 0.
  - synced != stable and counter == DEBOUNCE_CYCLES-1: stable ← synced, counter ← 0.
  - Otherwise: counter ← counter+1.
  - Any single-cycle agreement restarts the count; the counter never wraps.
- level_o = stable.
- press_o[i] is high in the cycle after the edge where stable[i] went 0→1. release_o[i] behaves the same for 1→0. Both are registered with stable, so they rise together with level_o.
- Event encoder, registered: evt_valid_o ← |press_o and evt_idx_o ← lowest set index of press_o. When evt_valid_o = 0, evt_idx_o holds its last value. Simultaneous presses report only the lowest index; higher channels remain visible on press_o.
- Reset values: all outputs 0; counters 0; stable 0.
- Reset mid-operation: all state is cleared immediately. A button held through reset is re-accepted as a fresh press after full latency.

## Timing
- Latency: treat the first clk edge that samples a new raw level as edge 1. level_o and press_o/release_o change after edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - Defaults: 500002 cycles.
  - SYNC_STAGES=2, DEBOUNCE_CYCLES=1: after edge 3.
- evt_valid_o/evt_idx_o: 1 cycle after press_o.
- Glitches shorter than DEBOUNCE_CYCLES cycles at the synchroniser output produce no output change.
- Minimum press→release spacing: DEBOUNCE_CYCLES cycles.

## Configuration
- INPUT_DETECT_REPEAT_EN defined: each channel has a repeat counter, cleared whenever stable=0 and on reset.
  - While stable=1, the counter counts from the press.
  - press_o re-pulses REPEAT_DELAY cycles after the original press_o pulse, then every REPEAT_PERIOD cycles while held.
  - Repeat pulses also drive evt_valid_o.
  - Release stops repeats in the same cycle stable falls; no repeat coincides with release_o.
- Not defined: no repeat logic is instantiated. REPEAT_* parameters are ignored, and press_o pulses exactly once per accepted press.

## Test plan
- Reset → all outputs 0. Then hold signal_i=4'b0001 (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4) → level_o[0] and press_o[0] rise after edge 6. press_o is one cycle wide. evt_valid_o=1, evt_idx_o=0 one cycle later.
- Bounce ch2: 3-cycle high, 1-cycle low, repeated, DEBOUNCE_CYCLES=4 → no press_o. Then hold 4+ cycles → exactly one press_o[2].
- Simultaneous press of ch1 and ch3 → press_o=4'b1010 for one cycle. evt_idx_o=1, single evt_valid_o pulse.
- ACTIVE_LOW=1: pins idle 1 through reset → no spurious press. Drive ch0 low → press. Drive high → release_o[0] after same latency.
- Assert rst while ch0 held and level_o[0]=1 → all outputs 0 the next cycle. Deassert with ch0 still held → new press_o[0] after SYNC_STAGES+DEBOUNCE_CYCLES edges.
- Repeat build (REPEAT_DELAY=10, REPEAT_PERIOD=3): hold ch0 → pulses at press, +10, +13, +16. Release → repeats cease, one release_o[0].
